sm3_digest_readout: RTL and testbench



---
 rtl/sm3_digest_readout.sv | 119 +++++++++++
 tb/tb_sm3_digest_readout.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sm3_digest_readout.sv
// SM3 digest readout: captures the finished 256-bit digest on the rise of
// hash_valid and returns it to the core one 32-bit word per read request.
module sm3_digest_readout #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned N_WORDS = 8,
    parameter int unsigned PTR_W   = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hash_valid,
    input  logic [DATA_W*N_WORDS-1:0]   hash_value,
    input  logic                        rd_en,
    input  logic                        clear,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rd_valid,
    output logic                        hold_pipline,
    output logic                        full,
    output logic                        done
);

    localparam int unsigned DIGEST_W = DATA_W * N_WORDS;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DIGEST_W-1:0] digest_q, digest_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                hv_q;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                done_q, done_d;
    logic                hv_rise;
    logic                last_word;
    logic [DATA_W-1:0]   words [N_WORDS];

    // Word 0 is the most significant word of the digest; no byte swapping.
    for (genvar i = 0; i < N_WORDS; i++) begin : g_words
        assign words[i] = digest_q[DATA_W*(N_WORDS-i)-1 -: DATA_W];
    end

    assign hv_rise   = hash_valid & ~hv_q;
    assign last_word = (ptr_q == PTR_W'(N_WORDS - 1));

    // State, pointer, digest and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            digest_q   <= '0;
            ptr_q      <= '0;
            hv_q       <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            digest_q   <= digest_d;
            ptr_q      <= ptr_d;
            hv_q       <= hash_valid;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic: clear outranks capture and reads; a rise in FULL is ignored.
    always_comb begin
        state_d    = state_q;
        digest_d   = digest_q;
        ptr_d      = ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;

        if (clear) begin
            state_d  = EMPTY;
            ptr_d    = '0;
            digest_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (hv_rise) begin
                        digest_d = hash_value;
                        ptr_d    = '0;
                        state_d  = FULL;
                    end
                end
                FULL: begin
                    if (rd_en) begin
                        rd_data_d  = words[ptr_q];
                        rd_valid_d = 1'b1;
                        if (last_word) begin
                            done_d   = 1'b1;
                            state_d  = EMPTY;
                            ptr_d    = '0;
                            digest_d = '0;
                        end else begin
                            ptr_d = ptr_q + PTR_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Stall is combinational so the core sees it in the request cycle.
    assign hold_pipline = rst & rd_en & ~clear & (state_q == EMPTY);

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign done     = done_q;
    assign full     = (state_q == FULL);

endmodule

// File: tb/tb_sm3_digest_readout.sv
// Directed bench for sm3_digest_readout using the SM3("abc") digest.
module tb_sm3_digest_readout;

    logic         clk;
    logic         rst;
    logic         hash_valid;
    logic [255:0] hash_value;
    logic         rd_en;
    logic         clear;
    logic [31:0]  rd_data;
    logic         rd_valid;
    logic         hold_pipline;
    logic         full;
    logic         done;

    int n_tests;
    int n_fail;

    logic [255:0] abc_digest;
    logic [31:0]  abc_w [8];

    sm3_digest_readout dut (
        .clk          (clk),
        .rst          (rst),
        .hash_valid   (hash_valid),
        .hash_value   (hash_value),
        .rd_en        (rd_en),
        .clear        (clear),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .hold_pipline (hold_pipline),
        .full         (full),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        abc_digest = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
        abc_w[0] = 32'h66c7f0f4; abc_w[1] = 32'h62eeedd9;
        abc_w[2] = 32'hd1f2d46b; abc_w[3] = 32'hdc10e4e2;
        abc_w[4] = 32'h4167c487; abc_w[5] = 32'h5cf2f7a2;
        abc_w[6] = 32'h297da02b; abc_w[7] = 32'h8f4ba8e0;

        rst        = 1'b0;
        hash_valid = 1'b0;
        hash_value = abc_digest;
        rd_en      = 1'b1;
        clear      = 1'b0;

        // Reset state, including no stall while in reset.
        tick(); tick();
        chk("rst_rd_data",  rd_data, 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_full",     32'(full), 32'h0);
        chk("rst_done",     32'(done), 32'h0);
        chk("rst_hold",     32'(hold_pipline), 32'h0);
        rd_en = 1'b0;
        rst   = 1'b1;
        tick();

        // Capture and back-to-back drain of eight words.
        hash_valid = 1'b1;
        tick();
        chk("cap_full", 32'(full), 32'h1);
        rd_en = 1'b1;
        #1;
        chk("full_hold", 32'(hold_pipline), 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("drain_w%0d", i), rd_data, abc_w[i]);
            chk($sformatf("drain_v%0d", i), 32'(rd_valid), 32'h1);
            chk($sformatf("drain_d%0d", i), 32'(done), (i == 7) ? 32'h1 : 32'h0);
        end
        rd_en = 1'b0;
        tick();
        chk("post_valid", 32'(rd_valid), 32'h0);
        chk("post_done",  32'(done), 32'h0);
        chk("post_full",  32'(full), 32'h0);
        chk("post_hold_data", rd_data, 32'h8f4ba8e0);

        // Level still high after drain: no re-capture, request stalls.
        rd_en = 1'b1;
        #1;
        chk("lvl_hold", 32'(hold_pipline), 32'h1);
        tick();
        chk("lvl_valid", 32'(rd_valid), 32'h0);
        chk("lvl_full",  32'(full), 32'h0);
        rd_en      = 1'b0;
        hash_valid = 1'b0;
        tick();
        hash_valid = 1'b1;
        tick();
        chk("recap_full", 32'(full), 32'h1);

        // Read three words, then a second digest pulse must be ignored.
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("r3_w%0d", i), rd_data, abc_w[i]);
        end
        rd_en      = 1'b0;
        hash_valid = 1'b0;
        tick();
        hash_valid = 1'b1;
        hash_value = {8{32'hffffffff}};
        tick();
        chk("ign_full", 32'(full), 32'h1);
        rd_en = 1'b1;
        for (int i = 3; i < 8; i++) begin
            tick();
            chk($sformatf("ign_w%0d", i), rd_data, abc_w[i]);
            chk($sformatf("ign_d%0d", i), 32'(done), (i == 7) ? 32'h1 : 32'h0);
        end
        rd_en      = 1'b0;
        hash_value = abc_digest;
        hash_valid = 1'b0;
        tick();

        // Stall with nothing held, then capture while rd_en is high.
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("empty_hold", 32'(hold_pipline), 32'h1);
            tick();
            chk("empty_valid", 32'(rd_valid), 32'h0);
        end
        hash_valid = 1'b1;
        #1;
        chk("capcyc_hold", 32'(hold_pipline), 32'h1);
        tick();
        chk("capcyc_valid", 32'(rd_valid), 32'h0);
        chk("capcyc_full",  32'(full), 32'h1);
        chk("served_hold",  32'(hold_pipline), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("r5_w%0d", i), rd_data, abc_w[i]);
        end

        // Clear together with rd_en: flush, no read, no stall.
        clear = 1'b1;
        #1;
        chk("clr_hold", 32'(hold_pipline), 32'h0);
        tick();
        chk("clr_valid", 32'(rd_valid), 32'h0);
        chk("clr_done",  32'(done), 32'h0);
        chk("clr_full",  32'(full), 32'h0);
        clear = 1'b0;
        #1;
        chk("clr_after_hold", 32'(hold_pipline), 32'h1);
        tick();
        chk("clr_after_valid", 32'(rd_valid), 32'h0);
        rd_en = 1'b0;

        // Reset mid-drain after two reads, then recapture on release.
        hash_valid = 1'b0;
        tick();
        hash_valid = 1'b1;
        tick();
        rd_en = 1'b1;
        tick();
        chk("mid_w0", rd_data, abc_w[0]);
        tick();
        chk("mid_w1", rd_data, abc_w[1]);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_data",  rd_data, 32'h0);
        chk("arst_valid", 32'(rd_valid), 32'h0);
        chk("arst_full",  32'(full), 32'h0);
        chk("arst_hold",  32'(hold_pipline), 32'h0);
        rd_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rel_full", 32'(full), 32'h1);
        rd_en = 1'b1;
        tick();
        chk("rel_w0", rd_data, abc_w[0]);
        chk("rel_v0", 32'(rd_valid), 32'h1);
        rd_en = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
